// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller for the IF/ID, ID/EX and EX/MEM registers.
// Optional hazard statistics counters are built when HAZARD_STATS_EN is defined.
module hazard_ctrl #(
    parameter int MDU_LAT     = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  ID_rs,
    input  logic [4:0]  ID_rt,
    input  logic        ID_use_rs,
    input  logic        ID_use_rt,
    input  logic        ID_use_hilo,
    input  logic        ID_jump,
    input  logic        ID_mdu_start,
    input  logic        EX_MemRd,
    input  logic [4:0]  EX_rt,
    input  logic        EX_br_taken,
    input  logic        mem_busy,
    output logic        PC_hold,
    output logic        IFID_hold,
    output logic        IFID_flush,
    output logic        IDEX_stall,
    output logic        pipe_freeze,
    output logic        mdu_busy,
    output logic        hazard_err,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    localparam logic [5:0] MDU_LOAD    = 6'(MDU_LAT);
    localparam logic [7:0] MEM_TIMEOUT_V = 8'(MEM_TIMEOUT);

    typedef enum logic {RUN, MEMWAIT} state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic [5:0] r_mdu_cnt;
    logic [7:0] r_mem_cnt;
    logic       r_hazard_err;

    logic w_load_use;
    logic w_mdu_haz;
    logic w_mdu_issue;
    logic w_pc_hold;
    logic w_ifid_hold;
    logic w_ifid_flush;
    logic w_idex_stall;
    logic w_pipe_freeze;

    assign w_load_use = EX_MemRd && (EX_rt != 5'd0) &&
                        ((ID_use_rs && (ID_rs == EX_rt)) || (ID_use_rt && (ID_rt == EX_rt)));
    assign w_mdu_haz  = ID_use_hilo && (r_mdu_cnt != 6'd0);

    // A new multiply/divide only issues when nothing above it in priority holds or kills ID.
    assign w_mdu_issue = ID_mdu_start && !mem_busy && !EX_br_taken && !w_load_use && !w_mdu_haz;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            RUN:     if (mem_busy)  w_next_state = MEMWAIT;
            MEMWAIT: if (!mem_busy) w_next_state = RUN;
            default: w_next_state = RUN;
        endcase
    end

    always_comb begin
        w_pc_hold     = 1'b0;
        w_ifid_hold   = 1'b0;
        w_ifid_flush  = 1'b0;
        w_idex_stall  = 1'b0;
        w_pipe_freeze = 1'b0;
        if (mem_busy) begin
            w_pipe_freeze = 1'b1;
            w_pc_hold     = 1'b1;
            w_ifid_hold   = 1'b1;
        end else if (EX_br_taken) begin
            w_ifid_flush  = 1'b1;
            w_idex_stall  = 1'b1;
        end else if (w_load_use || w_mdu_haz) begin
            w_pc_hold     = 1'b1;
            w_ifid_hold   = 1'b1;
            w_idex_stall  = 1'b1;
        end else if (ID_jump) begin
            w_ifid_flush  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mdu_cnt <= 6'd0;
        end else if (w_mdu_issue) begin
            r_mdu_cnt <= MDU_LOAD;
        end else if (r_mdu_cnt != 6'd0) begin
            r_mdu_cnt <= r_mdu_cnt - 6'd1;
        end
    end

    // The timeout compares the registered run length, so the error lands one edge after it saturates.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mem_cnt    <= 8'd0;
            r_hazard_err <= 1'b0;
        end else begin
            if (mem_busy) begin
                if (r_mem_cnt != 8'hFF) begin
                    r_mem_cnt <= r_mem_cnt + 8'd1;
                end
                if (r_mem_cnt >= MEM_TIMEOUT_V) begin
                    r_hazard_err <= 1'b1;
                end
            end else begin
                r_mem_cnt <= 8'd0;
            end
        end
    end

    assign PC_hold     = w_pc_hold     && !reset;
    assign IFID_hold   = w_ifid_hold   && !reset;
    assign IFID_flush  = w_ifid_flush  && !reset;
    assign IDEX_stall  = w_idex_stall  && !reset;
    assign pipe_freeze = w_pipe_freeze && !reset;
    assign mdu_busy    = (r_mdu_cnt != 6'd0) && !reset;
    assign hazard_err  = r_hazard_err  && !reset;

`ifdef HAZARD_STATS_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= 32'd0;
            r_flush_cnt <= 32'd0;
        end else begin
            if (w_pc_hold) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (w_ifid_flush) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`else
    assign stall_cnt = 32'h0;
    assign flush_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl (MDU_LAT=4); expected control vectors are queued
// at drive time and compared mid-cycle by a monitor, together with the stats counters.
module tb_hazard_ctrl;

    logic        clk;
    logic        reset;
    logic [4:0]  idRs;
    logic [4:0]  idRt;
    logic        idUseRs;
    logic        idUseRt;
    logic        idUseHilo;
    logic        idJump;
    logic        idMduStart;
    logic        exMemRd;
    logic [4:0]  exRt;
    logic        exBrTaken;
    logic        memBusy;
    logic        pcHold;
    logic        ifidHold;
    logic        ifidFlush;
    logic        idexStall;
    logic        pipeFreeze;
    logic        mduBusy;
    logic        hazardErr;
    logic [31:0] stallCnt;
    logic [31:0] flushCnt;

    // Vector order: PC_hold, IFID_hold, IFID_flush, IDEX_stall, pipe_freeze, mdu_busy, hazard_err
    logic [6:0] outVec;
    assign outVec = {pcHold, ifidHold, ifidFlush, idexStall, pipeFreeze, mduBusy, hazardErr};

    localparam logic [6:0] IDLE   = 7'b0000000;
    localparam logic [6:0] LUSE   = 7'b1101000;
    localparam logic [6:0] BRANCH = 7'b0011000;
    localparam logic [6:0] JUMP   = 7'b0010000;
    localparam logic [6:0] MDUST  = 7'b1101010;
    localparam logic [6:0] FREEZE = 7'b1100100;
    localparam logic [6:0] FRZMDU = 7'b1100110;
    localparam logic [6:0] ERRSET = 7'b0000001;

    typedef struct {
        string      tag;
        logic [6:0] exp;
        bit         rst;
        bit         chk;
    } entry_t;

    entry_t sbQ[$];
    int     checkCount = 0;
    int     errorCount = 0;
    int     modelStall = 0;
    int     modelFlush = 0;

    hazard_ctrl #(
        .MDU_LAT(4),
        .MEM_TIMEOUT(255)
    ) dut (
        .clk(clk),
        .reset(reset),
        .ID_rs(idRs),
        .ID_rt(idRt),
        .ID_use_rs(idUseRs),
        .ID_use_rt(idUseRt),
        .ID_use_hilo(idUseHilo),
        .ID_jump(idJump),
        .ID_mdu_start(idMduStart),
        .EX_MemRd(exMemRd),
        .EX_rt(exRt),
        .EX_br_taken(exBrTaken),
        .mem_busy(memBusy),
        .PC_hold(pcHold),
        .IFID_hold(ifidHold),
        .IFID_flush(ifidFlush),
        .IDEX_stall(idexStall),
        .pipe_freeze(pipeFreeze),
        .mdu_busy(mduBusy),
        .hazard_err(hazardErr),
        .stall_cnt(stallCnt),
        .flush_cnt(flushCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Inputs are set at a negedge by the caller; the entry is checked 2ns later by the monitor.
    task automatic applyStimulus(input string tag, input logic [6:0] exp, input bit chk = 1'b1);
        entry_t e;
        e.tag = tag;
        e.exp = exp;
        e.rst = reset;
        e.chk = chk;
        sbQ.push_back(e);
        @(negedge clk);
    endtask

    task automatic setIdle();
        idRs       = 5'd0;
        idRt       = 5'd0;
        idUseRs    = 1'b0;
        idUseRt    = 1'b0;
        idUseHilo  = 1'b0;
        idJump     = 1'b0;
        idMduStart = 1'b0;
        exMemRd    = 1'b0;
        exRt       = 5'd0;
        exBrTaken  = 1'b0;
        memBusy    = 1'b0;
    endtask

    task automatic setLoadUseRs();
        exMemRd = 1'b1;
        exRt    = 5'd8;
        idRs    = 5'd8;
        idUseRs = 1'b1;
    endtask

    // Counter model: DUT counters at this point reflect every earlier non-reset cycle.
    always @(negedge clk) begin
        entry_t e;
        #2;
        if (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            if (e.rst) begin
                modelStall = 0;
                modelFlush = 0;
            end
            if (e.chk) begin
                checkOutput(e.tag, 32'(outVec), 32'(e.exp));
`ifdef HAZARD_STATS_EN
                checkOutput({e.tag, "_stallCnt"}, stallCnt, 32'(modelStall));
                checkOutput({e.tag, "_flushCnt"}, flushCnt, 32'(modelFlush));
`else
                checkOutput({e.tag, "_stallCnt"}, stallCnt, 32'h0);
                checkOutput({e.tag, "_flushCnt"}, flushCnt, 32'h0);
`endif
            end
            if (!e.rst) begin
                if (e.exp[6]) modelStall++;
                if (e.exp[4]) modelFlush++;
            end
        end
    end

    initial begin
        reset = 1'b1;
        setIdle();
        @(negedge clk);
        applyStimulus("reset", IDLE);
        reset = 1'b0;

        // Load-use through rs, then the bubble cycle
        setLoadUseRs();
        applyStimulus("t1LoadUse", LUSE);
        exMemRd = 1'b0;
        applyStimulus("t1Release", IDLE);

        // $zero destination and unused rt never stall; used rt does
        setIdle(); exMemRd = 1'b1; exRt = 5'd0; idRs = 5'd0; idUseRs = 1'b1;
        applyStimulus("t2Zero", IDLE);
        setIdle(); exMemRd = 1'b1; exRt = 5'd8; idRt = 5'd8; idRs = 5'd3; idUseRs = 1'b1;
        applyStimulus("t2RtUnused", IDLE);
        idUseRt = 1'b1;
        applyStimulus("t2RtUsed", LUSE);
        setIdle();
        applyStimulus("t2Idle", IDLE);

        // Taken branch wins over load-use, jump and MDU issue
        setLoadUseRs(); exBrTaken = 1'b1; idJump = 1'b1; idMduStart = 1'b1;
        applyStimulus("t4Branch", BRANCH);
        setIdle();
        applyStimulus("t4After", IDLE);
        idJump = 1'b1;
        applyStimulus("jumpOnly", JUMP);
        setIdle();

        // MDU issue then hi/lo use stalls for MDU_LAT cycles
        idMduStart = 1'b1;
        applyStimulus("t3Start", IDLE);
        idMduStart = 1'b0; idUseHilo = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus($sformatf("t3Stall%0d", i), MDUST);
        applyStimulus("t3Release", IDLE);
        setIdle();

        // MDU issue suppressed by a concurrent load-use stall
        setLoadUseRs(); idMduStart = 1'b1;
        applyStimulus("mduBlocked", LUSE);
        setIdle();
        applyStimulus("mduNotIssued", IDLE);

        // MDU countdown continues while memory freezes the pipe
        idMduStart = 1'b1;
        applyStimulus("mduMemStart", IDLE);
        idMduStart = 1'b0; idUseHilo = 1'b1; memBusy = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus($sformatf("mduMemFreeze%0d", i), FRZMDU);
        memBusy = 1'b0;
        applyStimulus("mduMemLast", MDUST);
        applyStimulus("mduMemDone", IDLE);
        setIdle();

        // Memory wait dominates a pending load-use, which then stalls once
        setLoadUseRs(); memBusy = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus($sformatf("t5Freeze%0d", i), FREEZE);
        memBusy = 1'b0;
        applyStimulus("t5LoadUse", LUSE);
        setIdle();
        applyStimulus("t5Idle", IDLE);

        // Reset in the middle of an MDU stall clears everything
        idMduStart = 1'b1;
        applyStimulus("t6Start", IDLE);
        idMduStart = 1'b0; idUseHilo = 1'b1;
        applyStimulus("t6Stall0", MDUST);
        applyStimulus("t6Stall1", MDUST);
        reset = 1'b1;
        applyStimulus("t6Reset", IDLE);
        reset = 1'b0;
        applyStimulus("t6NoResidual", IDLE);
        setIdle();

        // Memory timeout: 256 busy cycles set a sticky error
        memBusy = 1'b1;
        for (int i = 0; i < 256; i++) begin
            applyStimulus($sformatf("memWait%0d", i), FREEZE, i < 200);
        end
        memBusy = 1'b0;
        applyStimulus("errSet", ERRSET);
        applyStimulus("errSticky", ERRSET);
        reset = 1'b1;
        applyStimulus("errReset", IDLE);
        reset = 1'b0;
        applyStimulus("errCleared", IDLE);

        #5;
        checkOutput("queueEmpty", 32'(sbQ.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
